buffer_uart_drain: RTL

//  Reader for the read side of Buffer: pops 9-bit words via data_out_valid/data_out_read and serialises them on a UART line.

---
 rtl/buffer_uart_drain.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/buffer_uart_drain.sv
// Drains 9-bit words from Buffer's read port and serialises them as UART frames (LSB first).
// Define BUF_UART_PARITY_EN to add an even-parity bit between the data bits and the stop bits.
module buffer_uart_drain #(
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] buf_data,
  input  logic              buf_valid,
  output logic              buf_read,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLK_DIV);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_tx, w_tx_nxt;
  logic                r_buf_read, w_read_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                w_bit_end, w_last_bit, w_capture;
`ifdef BUF_UART_PARITY_EN
  logic                r_par, w_par_nxt;
`endif

  assign w_bit_end  = (r_cnt == '0);
  assign w_last_bit = (r_idx == IDX_LAST);
  // A word is taken either from idle or on the final stop-bit edge (back-to-back frames).
  assign w_capture  = buf_valid && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_buf_read <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef BUF_UART_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_buf_read <= w_read_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef BUF_UART_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (buf_valid) w_state_nxt = START;
      START:  if (w_bit_end) w_state_nxt = DATA;
      DATA:
        if (w_bit_end && w_last_bit) begin
`ifdef BUF_UART_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      PARITY: if (w_bit_end) w_state_nxt = STOP;
      STOP:   if (w_bit_end) w_state_nxt = buf_valid ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_read_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef BUF_UART_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      START, DATA: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if ((r_state == DATA) && w_last_bit) begin
`ifdef BUF_UART_PARITY_EN
          w_tx_nxt  = r_par;
          w_cnt_nxt = BIT_LAST;
`else
          w_tx_nxt  = 1'b1;
          w_cnt_nxt = STOP_LAST;
`endif
        end else begin
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = (r_state == START) ? '0 : r_idx + 1'b1;
          w_cnt_nxt   = BIT_LAST;
        end
      end
      PARITY: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_tx_nxt  = 1'b1;
          w_cnt_nxt = STOP_LAST;
        end
      end
      STOP: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
          w_tx_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
    // Capture overrides the stop-bit wrap-up so back-to-back frames keep busy high.
    if (w_capture) begin
      w_shift_nxt = buf_data;
      w_read_nxt  = 1'b1;
      w_tx_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
      w_cnt_nxt   = BIT_LAST;
`ifdef BUF_UART_PARITY_EN
      w_par_nxt   = ^buf_data;
`endif
    end
  end

  assign buf_read = r_buf_read;
  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule
